// File: rtl/seq_mul_signed_acc_if.sv
// Operand/product handshake bundle for seq_mul_signed_acc.
// slave: the multiplier side; master: the client side.
interface seq_mul_signed_acc_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product,
    output busy
  );

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product,
    input  busy
  );
endinterface

// File: rtl/seq_mul_signed_acc.sv
// Iterative signed multiplier, one radix-4 term of b per cycle.
// Ports: clk, rst_n (async low), bus (slave: in/out handshakes, a, b, product, busy).
module seq_mul_signed_acc #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_mul_signed_acc_if.slave   bus
);
  localparam int N  = WIDTH / 2;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = WIDTH + 2;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [PW-1:0]    acc;
  logic [KW-1:0]    k;

  logic [1:0]       pairs [N];
  logic [1:0]       pair;
  logic             last;
  logic [TW-1:0]    a_ext;
  logic [TW-1:0]    two_a;
  logic [TW-1:0]    t1;
  logic [TW-1:0]    t2;
  logic             cin;
  logic [TW-1:0]    term;
  logic [PW-1:0]    term_ext;
  logic [PW-1:0]    term_sh;

  logic             accept;
  logic             drain;

  for (genvar i = 0; i < N; i++) begin : g_pair
    assign pairs[i] = b_r[2*i+1 -: 2];
  end

  assign pair  = pairs[k];
  assign last  = (k == KW'(N - 1));
  assign a_ext = {{2{a_r[WIDTH-1]}}, a_r};
  assign two_a = a_ext << 1;

  // Top pair carries the sign bit of b, so its 2A weight is negative:
  // invert and add one through the carry-in.
  assign t1   = pair[0] ? a_ext : '0;
  assign t2   = pair[1] ? (last ? ~two_a : two_a) : '0;
  assign cin  = last & pair[1];
  assign term = t1 + t2 + TW'(cin);

  assign term_ext = {{(PW-TW){term[TW-1]}}, term};
  assign term_sh  = term_ext << {k, 1'b0};

  assign accept = (state == IDLE) & bus.in_valid;
  assign drain  = (state == DONE) & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == IDLE): if (accept) state_nxt = RUN;
      (state == RUN):  if (last)   state_nxt = DONE;
      (state == DONE): if (drain)  state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.busy      = (state != IDLE);
    bus.product   = acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      k   <= '0;
    end else if (accept) begin
      a_r <= bus.a;
      b_r <= bus.b;
      acc <= '0;
      k   <= '0;
    end else if (state == RUN) begin
      acc <= acc + term_sh;
      k   <= k + KW'(1);
    end
  end
endmodule

// File: tb/tb_seq_mul_signed_acc.sv
// Directed bench for seq_mul_signed_acc at WIDTH=8.
// Checks latency, products, stalls, busy-time inputs and async reset.
module tb_seq_mul_signed_acc;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_mul_signed_acc_if #(.WIDTH(W)) bus ();

  seq_mul_signed_acc #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one pair, wait for out_valid, optionally stall, then drain.
  task automatic run_op(input string tag,
                        input logic [W-1:0] av,
                        input logic [W-1:0] bv,
                        input logic [2*W-1:0] exp,
                        input int stall);
    int n;
    bus.out_ready = (stall == 0);
    bus.a         = av;
    bus.b         = bv;
    bus.in_valid  = 1'b1;
    check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd4);
    check({tag, "_prod"}, 32'(bus.product), 32'(exp));
    for (int i = 0; i < stall; i++) begin
      step();
      check({tag, "_hold_v"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_p"}, 32'(bus.product), 32'(exp));
      check({tag, "_hold_r"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    step();
    check({tag, "_back"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_ov0"}, 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_product", 32'(bus.product), 32'd0);
    #10;
    rst_n = 1'b1;
    step();

    run_op("7x5", 8'd7, 8'd5, 16'd35, 0);
    run_op("m128xm128", 8'h80, 8'h80, 16'h4000, 0);
    run_op("m128x127", 8'h80, 8'h7F, 16'hC080, 0);
    run_op("m1xm1", 8'hFF, 8'hFF, 16'h0001, 0);
    run_op("127x127", 8'h7F, 8'h7F, 16'h3F01, 1);
    run_op("m128x1", 8'h80, 8'h01, 16'hFF80, 2);
    run_op("0xm77", 8'h00, 8'hB3, 16'h0000, 0);
    run_op("m7x9", 8'hF9, 8'h09, 16'hFFC1, 3);
    run_op("85xm86", 8'h55, 8'hAA, 16'hE372, 0);
    run_op("64xm128", 8'h40, 8'h80, 16'hE000, 0);
    run_op("stall6", 8'd12, 8'd11, 16'd132, 6);

    // New operands offered during RUN must not disturb the result.
    bus.out_ready = 1'b1;
    bus.a         = 8'd7;
    bus.b         = 8'd5;
    bus.in_valid  = 1'b1;
    step();
    bus.a = 8'hFF;
    bus.b = 8'h81;
    step();
    step();
    step();
    bus.in_valid = 1'b0;
    step();
    check("ign_valid", 32'(bus.out_valid), 32'd1);
    check("ign_prod", 32'(bus.product), 32'd35);
    step();
    check("ign_back", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
    run_op("after_ign", 8'd2, 8'd3, 16'd6, 0);

    // Async reset two accumulations into an operation.
    bus.a        = 8'd100;
    bus.b        = 8'd100;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    check("mid_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_prod", 32'(bus.product), 32'd0);
    #3;
    rst_n = 1'b1;
    step();
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);
    run_op("3xm2", 8'd3, 8'hFE, 16'hFFFA, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
